// File: rtl/stream_resizer_pk.sv
// Keep-qualified S-lane to M-lane stream resizer built around a lane-compacting buffer.
// Optional macro RESIZER_SPARSE_KEEP_EN: accept arbitrary sparse s_keep_i (default: low-aligned keep only).
module stream_resizer_pk #(
  parameter int S_KEEP_WIDTH = 3,
  parameter int M_KEEP_WIDTH = 2,
  parameter int T_DATA_WIDTH = 8,
  parameter int BUF_LANES    = 8,
  parameter int CW           = $clog2(BUF_LANES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic                    s_last_i,
  input  logic [S_KEEP_WIDTH-1:0] s_keep_i,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [S_KEEP_WIDTH],
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    m_last_o,
  output logic [M_KEEP_WIDTH-1:0] m_keep_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [M_KEEP_WIDTH],
  output logic [CW-1:0]           occupancy_o,
  output logic                    last_pending_o
);

  localparam int BW = BUF_LANES * T_DATA_WIDTH;
  localparam int AW = S_KEEP_WIDTH * T_DATA_WIDTH;

  logic [BW-1:0] r_buf;
  logic [CW-1:0] r_cnt;
  logic          r_lastPending;

  logic          w_push;
  logic          w_loadOk;
  logic          w_popFull;
  logic          w_popPart;
  logic          w_popZero;
  logic          w_load;
  logic          w_emitLast;
  logic [CW-1:0] w_n;
  logic [CW-1:0] w_popCnt;
  logic [CW-1:0] w_base;
  logic [CW-1:0] w_cntNext;
  logic [AW-1:0] w_app;
  logic [BW-1:0] w_shifted;
  logic [BW-1:0] w_insMask;
  logic [BW-1:0] w_insData;
  logic [BW-1:0] w_bufNext;

  always_comb begin
    w_n = '0;
    for (int k = 0; k < S_KEEP_WIDTH; k++) w_n = w_n + CW'(s_keep_i[k]);
  end

`ifdef RESIZER_SPARSE_KEEP_EN
  // Input lane k lands in packed slot j when it is kept and exactly j kept lanes precede it.
  always_comb begin
    logic [CW-1:0] pre;
    w_app = '0;
    pre   = '0;
    for (int k = 0; k < S_KEEP_WIDTH; k++) begin
      for (int j = 0; j < S_KEEP_WIDTH; j++) begin
        if (s_keep_i[k] && (pre == CW'(j))) w_app[j*T_DATA_WIDTH +: T_DATA_WIDTH] = s_data_i[k];
      end
      pre = pre + CW'(s_keep_i[k]);
    end
  end
`else
  always_comb begin
    w_app = '0;
    for (int k = 0; k < S_KEEP_WIDTH; k++) w_app[k*T_DATA_WIDTH +: T_DATA_WIDTH] = s_data_i[k];
  end
`endif

  // Ready looks only at pre-pop occupancy, so a same-cycle pop can never be relied on to make room.
  assign s_ready_o  = !rst && !r_lastPending && ((CW'(BUF_LANES) - r_cnt) >= CW'(S_KEEP_WIDTH));
  assign w_push     = s_valid_i && s_ready_o;

  assign w_loadOk   = !m_valid_o || m_ready_i;
  assign w_popFull  = w_loadOk && (r_cnt >= CW'(M_KEEP_WIDTH));
  assign w_popPart  = w_loadOk && r_lastPending && !w_popFull && (r_cnt != '0);
  assign w_popZero  = w_loadOk && r_lastPending && (r_cnt == '0);
  assign w_load     = w_popFull || w_popPart || w_popZero;
  assign w_popCnt   = w_popFull ? CW'(M_KEEP_WIDTH) : (w_popPart ? r_cnt : '0);
  assign w_emitLast = w_popFull ? (r_lastPending && (r_cnt == CW'(M_KEEP_WIDTH)))
                                : (w_popPart || w_popZero);

  assign w_base     = r_cnt - w_popCnt;
  assign w_cntNext  = w_base + (w_push ? w_n : '0);

  // Lanes beyond the count are don't-care, so the whole S-lane slot is overwritten on append.
  assign w_shifted  = r_buf >> (w_popCnt * T_DATA_WIDTH);
  assign w_insMask  = BW'({AW{1'b1}}) << (w_base * T_DATA_WIDTH);
  assign w_insData  = BW'(w_app) << (w_base * T_DATA_WIDTH);
  assign w_bufNext  = w_push ? ((w_shifted & ~w_insMask) | w_insData) : w_shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf         <= '0;
      r_cnt         <= '0;
      r_lastPending <= 1'b0;
      m_valid_o     <= 1'b0;
      m_last_o      <= 1'b0;
      m_keep_o      <= '0;
      for (int i = 0; i < M_KEEP_WIDTH; i++) m_data_o[i] <= '0;
    end else begin
      r_buf <= w_bufNext;
      r_cnt <= w_cntNext;
      if (w_push && s_last_i) begin
        r_lastPending <= 1'b1;
      end else if (w_load && w_emitLast) begin
        r_lastPending <= 1'b0;
      end
      if (w_load) begin
        m_valid_o <= 1'b1;
        m_last_o  <= w_emitLast;
        for (int i = 0; i < M_KEEP_WIDTH; i++) begin
          m_keep_o[i] <= (CW'(i) < w_popCnt);
          m_data_o[i] <= (CW'(i) < w_popCnt) ? r_buf[i*T_DATA_WIDTH +: T_DATA_WIDTH] : '0;
        end
      end else if (m_ready_i) begin
        m_valid_o <= 1'b0;
      end
    end
  end

  assign occupancy_o    = r_cnt;
  assign last_pending_o = r_lastPending;

endmodule

// File: tb/tb_stream_resizer_pk.sv
// Directed self-checking bench for stream_resizer_pk (S=3, M=2, T=8, BUF_LANES=8).
// Expected output beats are hand-computed and packed as {last, keep[1:0], lane1, lane0}.
module tb_stream_resizer_pk;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid_i = 1'b0;
  logic       s_ready_o;
  logic       s_last_i = 1'b0;
  logic [2:0] s_keep_i = 3'b000;
  logic [7:0] s_data_i [3];
  logic       m_valid_o;
  logic       m_ready_i = 1'b1;
  logic       m_last_o;
  logic [1:0] m_keep_o;
  logic [7:0] m_data_o [2];
  logic [3:0] occupancy_o;
  logic       last_pending_o;

  int          compareCount  = 0;
  int          mismatchCount = 0;
  logic [31:0] obsQ[$];
  logic [31:0] expQ[$];
  logic        collect = 1'b1;

  stream_resizer_pk #(
    .S_KEEP_WIDTH(3),
    .M_KEEP_WIDTH(2),
    .T_DATA_WIDTH(8),
    .BUF_LANES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .s_last_i(s_last_i),
    .s_keep_i(s_keep_i),
    .s_data_i(s_data_i),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_last_o(m_last_o),
    .m_keep_o(m_keep_o),
    .m_data_o(m_data_o),
    .occupancy_o(occupancy_o),
    .last_pending_o(last_pending_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mkBeat(input logic last, input logic [1:0] keep,
                                         input logic [7:0] d1, input logic [7:0] d0);
    return {13'b0, last, keep, d1, d0};
  endfunction

  // Inputs change at posedge+1, so the negedge sees a settled handshake for the next edge.
  always @(negedge clk) begin
    if (collect && m_valid_o && m_ready_i)
      obsQ.push_back(mkBeat(m_last_o, m_keep_o, m_data_o[1], m_data_o[0]));
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic applyStimulus(input logic [2:0] keep, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic last);
    int waitCnt;
    waitCnt     = 0;
    s_valid_i   = 1'b1;
    s_keep_i    = keep;
    s_data_i[0] = d0;
    s_data_i[1] = d1;
    s_data_i[2] = d2;
    s_last_i    = last;
    @(negedge clk);
    while (!s_ready_o && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("acceptBeat", 32'(s_ready_o), 32'd1);
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    s_keep_i  = 3'b000;
  endtask

  task automatic checkBeats(input string tag);
    int cycles;
    cycles = 0;
    while (obsQ.size() < expQ.size() && cycles < 300) begin
      @(posedge clk);
      cycles++;
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput($sformatf("%s count", tag), 32'(obsQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++)
      checkOutput($sformatf("%s beat%0d", tag, i), (i < obsQ.size()) ? obsQ[i] : 32'hDEAD_BEEF, expQ[i]);
    obsQ.delete();
    expQ.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    s_data_i[0] = 8'h00;
    s_data_i[1] = 8'h00;
    s_data_i[2] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst m_valid", 32'(m_valid_o), 32'd0);
    checkOutput("rst m_last", 32'(m_last_o), 32'd0);
    checkOutput("rst m_keep", 32'(m_keep_o), 32'd0);
    checkOutput("rst m_data0", 32'(m_data_o[0]), 32'd0);
    checkOutput("rst m_data1", 32'(m_data_o[1]), 32'd0);
    checkOutput("rst occupancy", 32'(occupancy_o), 32'd0);
    checkOutput("rst lastPending", 32'(last_pending_o), 32'd0);
    checkOutput("rst s_ready", 32'(s_ready_o), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle s_ready", 32'(s_ready_o), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] two full beats repacked into three");
    applyStimulus(3'b111, 8'hA1, 8'hA2, 8'hA3, 1'b0);
    applyStimulus(3'b111, 8'hA4, 8'hA5, 8'hA6, 1'b1);
    expQ.push_back(mkBeat(1'b0, 2'b11, 8'hA2, 8'hA1));
    expQ.push_back(mkBeat(1'b0, 2'b11, 8'hA4, 8'hA3));
    expQ.push_back(mkBeat(1'b1, 2'b11, 8'hA6, 8'hA5));
    checkBeats("fullBeats");

    $display("[TB] single-lane packet flushed as partial beat");
    applyStimulus(3'b001, 8'h5A, 8'hEE, 8'hEE, 1'b1);
    expQ.push_back(mkBeat(1'b1, 2'b01, 8'h00, 8'h5A));
    checkBeats("partial");

    $display("[TB] keep=101 beat");
    applyStimulus(3'b101, 8'h11, 8'h22, 8'h33, 1'b1);
`ifdef RESIZER_SPARSE_KEEP_EN
    expQ.push_back(mkBeat(1'b1, 2'b11, 8'h33, 8'h11));
`else
    expQ.push_back(mkBeat(1'b1, 2'b11, 8'h22, 8'h11));
`endif
    checkBeats("keep101");

    $display("[TB] backpressure with a long stream");
    m_ready_i = 1'b0;
    applyStimulus(3'b111, 8'd1, 8'd2, 8'd3, 1'b0);
    applyStimulus(3'b111, 8'd4, 8'd5, 8'd6, 1'b0);
    applyStimulus(3'b111, 8'd7, 8'd8, 8'd9, 1'b0);
    checkOutput("bp occupancy", 32'(occupancy_o), 32'd7);
    checkOutput("bp s_ready", 32'(s_ready_o), 32'd0);
    checkOutput("bp m_valid", 32'(m_valid_o), 32'd1);
    checkOutput("bp held beat", mkBeat(m_last_o, m_keep_o, m_data_o[1], m_data_o[0]),
                mkBeat(1'b0, 2'b11, 8'd2, 8'd1));
    repeat (4) @(posedge clk);
    #1;
    checkOutput("bp stable beat", mkBeat(m_last_o, m_keep_o, m_data_o[1], m_data_o[0]),
                mkBeat(1'b0, 2'b11, 8'd2, 8'd1));
    checkOutput("bp stable occupancy", 32'(occupancy_o), 32'd7);
    fork
      begin
        applyStimulus(3'b111, 8'd10, 8'd11, 8'd12, 1'b0);
        applyStimulus(3'b111, 8'd13, 8'd14, 8'd15, 1'b0);
        applyStimulus(3'b111, 8'd16, 8'd17, 8'd18, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        m_ready_i = 1'b1;
      end
    join
    for (int i = 0; i < 9; i++)
      expQ.push_back(mkBeat(i == 8, 2'b11, 8'(2 * i + 2), 8'(2 * i + 1)));
    checkBeats("backpressure");

    $display("[TB] zero-keep last beat on empty buffer");
    applyStimulus(3'b000, 8'hEE, 8'hEE, 8'hEE, 1'b1);
    checkOutput("zk lastPending set", 32'(last_pending_o), 32'd1);
    expQ.push_back(mkBeat(1'b1, 2'b00, 8'h00, 8'h00));
    checkBeats("zeroKeep");
    checkOutput("zk lastPending clear", 32'(last_pending_o), 32'd0);

    $display("[TB] reset in the middle of a packet");
    collect = 1'b0;
    applyStimulus(3'b111, 8'h21, 8'h22, 8'h23, 1'b0);
    applyStimulus(3'b111, 8'h24, 8'h25, 8'h26, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid rst m_valid", 32'(m_valid_o), 32'd0);
    checkOutput("mid rst occupancy", 32'(occupancy_o), 32'd0);
    checkOutput("mid rst lastPending", 32'(last_pending_o), 32'd0);
    obsQ.delete();
    collect = 1'b1;
    applyStimulus(3'b111, 8'h31, 8'h32, 8'h33, 1'b1);
    expQ.push_back(mkBeat(1'b0, 2'b11, 8'h32, 8'h31));
    expQ.push_back(mkBeat(1'b1, 2'b01, 8'h00, 8'h33));
    checkBeats("afterReset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
